// File: rtl/intra_ref_idx_pipe_if.sv
// Beat bus between the intra scan controller, the reference index pipe
// and the reference-sample fetch/filter datapath.
interface intra_ref_idx_pipe_if #(
    parameter int LANES = 8,
    parameter int POS_W = 6,
    parameter int BANKS = 8,
    parameter int PIX   = 4
);
    localparam int BW = $clog2(BANKS);
    localparam int PW = $clog2(PIX);

    logic                   in_valid;
    logic                   in_ready;
    logic                   tu_start;
    logic [5:0]             mode;
    logic [2:0]             tu_size;
    logic [LANES*POS_W-1:0] ref_pos;
    logic [LANES*2-1:0]     ref_flag;
    logic                   map_load;
    logic [BANKS*BW-1:0]    map_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*BW-1:0]    out_bank_mid;
    logic [LANES*BW-1:0]    out_bank_lt;
    logic [LANES*BW-1:0]    out_bank_rt;
    logic [LANES*PW-1:0]    out_pix_mid;
    logic [LANES*PW-1:0]    out_pix_lt;
    logic [LANES*PW-1:0]    out_pix_rt;
    logic [LANES*2-1:0]     out_mid_opt;
    logic [LANES-1:0]       out_edge_mask;
    logic [LANES-1:0]       out_n_tl_nmax;
    logic                   out_ref_filter;
    logic                   out_err;

    modport master (
        output in_valid, tu_start, mode, tu_size, ref_pos, ref_flag,
        output map_load, map_data, out_ready,
        input  in_ready, out_valid, out_bank_mid, out_bank_lt, out_bank_rt,
        input  out_pix_mid, out_pix_lt, out_pix_rt, out_mid_opt,
        input  out_edge_mask, out_n_tl_nmax, out_ref_filter, out_err
    );

    modport slave (
        input  in_valid, tu_start, mode, tu_size, ref_pos, ref_flag,
        input  map_load, map_data, out_ready,
        output in_ready, out_valid, out_bank_mid, out_bank_lt, out_bank_rt,
        output out_pix_mid, out_pix_lt, out_pix_rt, out_mid_opt,
        output out_edge_mask, out_n_tl_nmax, out_ref_filter, out_err
    );
endinterface

// File: rtl/intra_ref_idx_pipe.sv
// Intra reference bank/pixel index mapping with filter options,
// two-stage valid/ready pipeline and TU-boundary bank map commit.
module intra_ref_idx_pipe #(
    parameter int LANES     = 8,
    parameter int POS_W     = 6,
    parameter int BANKS     = 8,
    parameter int PIX       = 4,
    parameter bit IS_CHROMA = 1'b0
) (
    input logic clk,
    input logic rst,
    intra_ref_idx_pipe_if.slave bus
);
    localparam int BW = $clog2(BANKS);
    localparam int PW = $clog2(PIX);

    typedef logic [BW-1:0] bank_t;

    typedef struct packed {
        logic [LANES*BW-1:0] bankMid;
        logic [LANES*BW-1:0] bankLt;
        logic [LANES*BW-1:0] bankRt;
        logic [LANES*PW-1:0] pixMid;
        logic [LANES*PW-1:0] pixLt;
        logic [LANES*PW-1:0] pixRt;
        logic [LANES*2-1:0]  midOpt;
        logic [LANES-1:0]    edgeMask;
        logic [LANES-1:0]    nTlNmax;
        logic                refFilter;
        logic                err;
    } beat_t;

    logic s1Valid, s2Valid, s1Load, s2Load;
    logic accept, commit, pendFlag;
    logic err, refFilter;
    logic [POS_W-1:0] maxIdx;
    beat_t dec, s1Data, s2Data;
    bank_t actMap  [BANKS];
    bank_t pendMap [BANKS];
    bank_t loadMap [BANKS];
    bank_t useMap  [BANKS];

    // Left references run down the bank order; top-left always sits in bank 0.
    function automatic bank_t rawOf(input logic [POS_W-1:0] q,
                                    input logic [1:0] f);
        if (f[1]) return '0;
        if (f[0]) return bank_t'(BANKS - 1) - bank_t'(q >> PW);
        return bank_t'(q >> PW);
    endfunction

    assign s2Load      = !s2Valid || bus.out_ready;
    assign s1Load      = !s1Valid || s2Load;
    assign bus.in_ready = s1Load;
    assign accept      = bus.in_valid && s1Load;
    assign commit      = accept && bus.tu_start;

    always_comb begin
        for (int i = 0; i < BANKS; i++)
            loadMap[i] = bus.map_data[(BANKS-i)*BW-1 -: BW];
    end

    always_comb begin
        useMap = actMap;
        if (commit) begin
            if (bus.map_load)  useMap = loadMap;
            else if (pendFlag) useMap = pendMap;
        end
    end

    assign err    = (bus.tu_size < 3'd2) || (bus.tu_size > 3'd5);
    assign maxIdx = POS_W'((32'd2 << bus.tu_size) - 32'd1);

    always_comb begin
        refFilter = 1'b1;
        if (IS_CHROMA || err || bus.tu_size == 3'd2 || bus.mode == 6'd1)
            refFilter = 1'b0;
        if (bus.tu_size == 3'd4 &&
            bus.mode inside {6'd9, 6'd10, 6'd11, 6'd25, 6'd26, 6'd27})
            refFilter = 1'b0;
        if (bus.tu_size == 3'd5 && bus.mode inside {6'd10, 6'd26})
            refFilter = 1'b0;
        if (bus.tu_size == 3'd3 &&
            !(bus.mode inside {6'd0, 6'd2, 6'd18, 6'd34}))
            refFilter = 1'b0;
    end

    always_comb begin : decode
        logic [POS_W-1:0] p, pm, pp;
        logic [1:0] f;
        dec = '0;
        p   = '0;
        pm  = '0;
        pp  = '0;
        f   = '0;
        for (int t = 0; t < LANES; t++) begin
            p  = bus.ref_pos[(LANES-t)*POS_W-1 -: POS_W];
            f  = bus.ref_flag[(LANES-t)*2-1 -: 2];
            pm = p - POS_W'(1);
            pp = p + POS_W'(1);
            dec.bankMid[(LANES-t)*BW-1 -: BW] = useMap[rawOf(p, f)];
            dec.bankLt[(LANES-t)*BW-1 -: BW]  = useMap[rawOf(pm, f)];
            dec.bankRt[(LANES-t)*BW-1 -: BW]  = useMap[rawOf(pp, f)];
            dec.pixMid[(LANES-t)*PW-1 -: PW]  = p[PW-1:0];
            dec.pixLt[(LANES-t)*PW-1 -: PW]   = pm[PW-1:0];
            dec.pixRt[(LANES-t)*PW-1 -: PW]   = pp[PW-1:0];
            if (f[1])
                dec.midOpt[(LANES-t)*2-1 -: 2] = 2'd0;
            else if (p != '0)
                dec.midOpt[(LANES-t)*2-1 -: 2] = 2'd3;
            else if (f[0])
                dec.midOpt[(LANES-t)*2-1 -: 2] = 2'd2;
            else
                dec.midOpt[(LANES-t)*2-1 -: 2] = 2'd1;
            dec.edgeMask[t] = refFilter && !f[1] && (p != maxIdx);
            dec.nTlNmax[t]  = (f != 2'd2) && (p != '1);
        end
        dec.refFilter = refFilter;
        dec.err       = err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s1Data  <= '0;
            s2Data  <= '0;
        end else begin
            if (s1Load) begin
                s1Valid <= accept;
                if (accept) s1Data <= dec;
            end
            if (s2Load) begin
                s2Valid <= s1Valid;
                if (s1Valid) s2Data <= s1Data;
            end
        end
    end

    // A committing beat already decoded with useMap, so active takes it as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            pendFlag <= 1'b0;
            for (int i = 0; i < BANKS; i++) begin
                actMap[i]  <= bank_t'(i);
                pendMap[i] <= '0;
            end
        end else if (commit) begin
            actMap   <= useMap;
            pendFlag <= 1'b0;
        end else if (bus.map_load) begin
            pendMap  <= loadMap;
            pendFlag <= 1'b1;
        end
    end

    assign bus.out_valid      = s2Valid;
    assign bus.out_bank_mid   = s2Data.bankMid;
    assign bus.out_bank_lt    = s2Data.bankLt;
    assign bus.out_bank_rt    = s2Data.bankRt;
    assign bus.out_pix_mid    = s2Data.pixMid;
    assign bus.out_pix_lt     = s2Data.pixLt;
    assign bus.out_pix_rt     = s2Data.pixRt;
    assign bus.out_mid_opt    = s2Data.midOpt;
    assign bus.out_edge_mask  = s2Data.edgeMask;
    assign bus.out_n_tl_nmax  = s2Data.nTlNmax;
    assign bus.out_ref_filter = s2Data.refFilter;
    assign bus.out_err        = s2Data.err;
endmodule

// File: tb/tb_intra_ref_idx_pipe.sv
// Directed bench for intra_ref_idx_pipe: lane-0 index mapping, filter
// table, backpressure, bank map commit and mid-flight reset.
module tb_intra_ref_idx_pipe;
    localparam int LANES = 8;
    localparam int POS_W = 6;
    localparam int BANKS = 8;
    localparam int PIX   = 4;
    localparam int BW    = 3;
    localparam int PW    = 2;
    localparam int NT    = 17;

    logic clk = 1'b0;
    logic rst;
    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    intra_ref_idx_pipe_if #(
        .LANES(LANES), .POS_W(POS_W), .BANKS(BANKS), .PIX(PIX)
    ) bus ();

    intra_ref_idx_pipe #(
        .LANES(LANES), .POS_W(POS_W), .BANKS(BANKS), .PIX(PIX),
        .IS_CHROMA(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [BW-1:0] bankMid0, bankLt0, bankRt0;
    logic [PW-1:0] pixMid0, pixLt0, pixRt0;
    logic [1:0]    opt0;
    assign bankMid0 = bus.out_bank_mid[LANES*BW-1 -: BW];
    assign bankLt0  = bus.out_bank_lt[LANES*BW-1 -: BW];
    assign bankRt0  = bus.out_bank_rt[LANES*BW-1 -: BW];
    assign pixMid0  = bus.out_pix_mid[LANES*PW-1 -: PW];
    assign pixLt0   = bus.out_pix_lt[LANES*PW-1 -: PW];
    assign pixRt0   = bus.out_pix_rt[LANES*PW-1 -: PW];
    assign opt0     = bus.out_mid_opt[LANES*2-1 -: 2];

    logic [BANKS*BW-1:0] idMap, revMap;

    // mode, tu, pos, flag -> refFilter, err, edge, nTlNmax, midOpt
    int tMode[NT] = '{2, 2, 26, 18, 18, 5, 2, 0, 2, 2, 10, 1, 2, 0, 2, 3, 18};
    int tTu  [NT] = '{3, 3, 4, 5, 3, 3, 6, 3, 3, 3, 5, 4, 2, 1, 3, 4, 5};
    int tPos [NT] = '{5, 0, 5, 5, 5, 5, 5, 15, 63, 5, 5, 5, 5, 5, 0, 31, 63};
    int tFlag[NT] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3, 0};
    int eRf  [NT] = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    int eErr [NT] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int eEdge[NT] = '{1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    int eNtl [NT] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int eOpt [NT] = '{3, 2, 3, 3, 3, 3, 3, 3, 3, 0, 3, 3, 3, 3, 1, 0, 3};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setBeat(input logic ts, input logic [5:0] md,
                           input logic [2:0] tu, input logic [5:0] pos,
                           input logic [1:0] fl);
        bus.tu_start = ts;
        bus.mode     = md;
        bus.tu_size  = tu;
        bus.ref_pos  = '0;
        bus.ref_flag = '0;
        bus.ref_pos[LANES*POS_W-1 -: POS_W] = pos;
        bus.ref_flag[LANES*2-1 -: 2]        = fl;
    endtask

    // Called at a negedge with the pipe draining; returns cycles to out_valid.
    task automatic runBeat(input logic ts, input logic ml,
                           input logic [BANKS*BW-1:0] md,
                           input logic [5:0] mode, input logic [2:0] tu,
                           input logic [5:0] pos, input logic [1:0] fl,
                           output int lat);
        setBeat(ts, mode, tu, pos, fl);
        bus.map_load = ml;
        bus.map_data = md;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.tu_start = 1'b0;
        bus.map_load = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sent, got, cyc, seen;
        logic held;
        logic [31:0] snap;

        for (int i = 0; i < BANKS; i++) begin
            idMap[(BANKS-i)*BW-1 -: BW]  = BW'(i);
            revMap[(BANKS-i)*BW-1 -: BW] = BW'(BANKS - 1 - i);
        end
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.map_load  = 1'b0;
        bus.map_data  = '0;
        setBeat(1'b0, 6'd0, 3'd3, 6'd0, 2'd0);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_bank", 32'(bus.out_bank_mid), 0);
        check("rst_rf", 32'(bus.out_ref_filter), 0);
        rst = 1'b0;
        @(negedge clk);

        runBeat(1'b0, 1'b0, '0, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("b1_lat", lat, 2);
        check("b1_valid", 32'(bus.out_valid), 1);
        check("b1_bmid", 32'(bankMid0), 1);
        check("b1_blt", 32'(bankLt0), 1);
        check("b1_brt", 32'(bankRt0), 1);
        check("b1_pmid", 32'(pixMid0), 1);
        check("b1_plt", 32'(pixLt0), 0);
        check("b1_prt", 32'(pixRt0), 2);
        check("b1_opt", 32'(opt0), 3);
        check("b1_rf", 32'(bus.out_ref_filter), 1);
        check("b1_edge", 32'(bus.out_edge_mask[0]), 1);

        runBeat(1'b0, 1'b0, '0, 6'd2, 3'd3, 6'd0, 2'd1, lat);
        check("b2_bmid", 32'(bankMid0), 7);
        check("b2_blt", 32'(bankLt0), 0);
        check("b2_brt", 32'(bankRt0), 7);
        check("b2_plt", 32'(pixLt0), 3);
        check("b2_opt", 32'(opt0), 2);
        check("b2_ntl", 32'(bus.out_n_tl_nmax[0]), 1);

        runBeat(1'b0, 1'b0, '0, 6'd2, 3'd3, 6'd20, 2'd3, lat);
        check("tl_bmid", 32'(bankMid0), 0);
        check("tl_brt", 32'(bankRt0), 0);
        check("tl_prt", 32'(pixRt0), 1);

        for (int i = 0; i < NT; i++) begin
            runBeat(1'b0, 1'b0, '0, 6'(tMode[i]), 3'(tTu[i]),
                    6'(tPos[i]), 2'(tFlag[i]), lat);
            check($sformatf("tab%0d_lat", i), lat, 2);
            check($sformatf("tab%0d_rf", i), 32'(bus.out_ref_filter), eRf[i]);
            check($sformatf("tab%0d_err", i), 32'(bus.out_err), eErr[i]);
            check($sformatf("tab%0d_edge", i),
                  32'(bus.out_edge_mask[0]), eEdge[i]);
            check($sformatf("tab%0d_ntl", i),
                  32'(bus.out_n_tl_nmax[0]), eNtl[i]);
            check($sformatf("tab%0d_opt", i), 32'(opt0), eOpt[i]);
        end
        @(negedge clk);

        sent = 0;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        snap = '0;
        while ((sent < 6 || got < 6) && cyc < 40) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (held)
                check("bp_stable", {26'd0, bankMid0, pixMid0, bus.out_valid},
                      snap);
            held = bus.out_valid && !bus.out_ready;
            snap = {26'd0, bankMid0, pixMid0, bus.out_valid};
            if (!bus.out_ready)
                check("bp_inready", 32'(bus.in_ready), 0);
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", {27'd0, bankMid0, pixMid0}, 5 * got + 1);
                got++;
            end
            if (sent < 6) begin
                setBeat(1'b0, 6'd2, 3'd3, 6'(5 * sent + 1), 2'd0);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_sent", sent, 6);
        check("bp_got", got, 6);

        bus.map_load = 1'b1;
        bus.map_data = revMap;
        @(negedge clk);
        bus.map_load = 1'b0;
        runBeat(1'b0, 1'b0, '0, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("map_pend0", 32'(bankMid0), 1);
        runBeat(1'b0, 1'b0, '0, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("map_pend1", 32'(bankMid0), 1);
        runBeat(1'b1, 1'b0, '0, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("map_commit", 32'(bankMid0), 6);
        check("map_commit_lt", 32'(bankLt0), 6);
        runBeat(1'b0, 1'b0, '0, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("map_after", 32'(bankMid0), 6);
        runBeat(1'b1, 1'b1, idMap, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("map_same_id", 32'(bankMid0), 1);
        runBeat(1'b1, 1'b1, revMap, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("map_same_rev", 32'(bankMid0), 6);

        setBeat(1'b0, 6'd2, 3'd3, 6'd5, 2'd0);
        bus.in_valid = 1'b1;
        bus.map_load = 1'b1;
        bus.map_data = revMap;
        @(negedge clk);
        bus.map_load = 1'b0;
        @(negedge clk);
        check("rst_inflight", 32'(bus.out_valid), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_valid", 32'(bus.out_valid), 0);
        check("rst2_ready", 32'(bus.in_ready), 1);
        check("rst2_data", 32'(bus.out_bank_mid), 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst2_flush", seen, 0);
        runBeat(1'b1, 1'b0, '0, 6'd2, 3'd3, 6'd5, 2'd0, lat);
        check("rst2_lat", lat, 2);
        check("rst2_map", 32'(bankMid0), 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
